// File: rtl/mem_access_master.sv
// Single-beat initiator for a generic single-port memory (add/datw/datr/en/we).
// Define READBACK_CHECK_EN to follow every write with a verify read that sets sticky chk_err.
module mem_access_master #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned GAP    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_add,
    input  logic [DW-1:0] cmd_dat,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_datw,
    output logic          mem_en,
    output logic          mem_we,
    input  logic [DW-1:0] mem_datr,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_dat,
    output logic          busy,
    output logic          chk_err
);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StRdWait,
        StGap
`ifdef READBACK_CHECK_EN
        , StVerify
`endif
    } state_e;

    // GAP=0 wraps GapLoad, but the gap state is never entered in that case.
    localparam logic [3:0] RdLoad  = 4'(RD_LAT - 1);
    localparam logic [3:0] GapLoad = 4'(GAP - 1);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       we_q;

    assign cmd_ready = (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            mem_add   <= '0;
            mem_datw  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            busy      <= 1'b0;
`ifdef READBACK_CHECK_EN
            chk_err   <= 1'b0;
`endif
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        we_q    <= cmd_we;
                        mem_add <= cmd_add;
                        if (cmd_we) begin
                            mem_datw <= cmd_dat;
                        end
                        mem_en  <= 1'b1;
                        mem_we  <= cmd_we;
                        busy    <= 1'b1;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (we_q) begin
`ifdef READBACK_CHECK_EN
                        // Verify read reuses the held address; mem_we stays low.
                        mem_en  <= 1'b1;
                        state_q <= StVerify;
`else
                        if (GAP == 0) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            cnt_q   <= GapLoad;
                            state_q <= StGap;
                        end
`endif
                    end else begin
                        cnt_q   <= RdLoad;
                        state_q <= StRdWait;
                    end
                end
`ifdef READBACK_CHECK_EN
                StVerify: begin
                    cnt_q   <= RdLoad;
                    state_q <= StRdWait;
                end
`endif
                StRdWait: begin
                    if (cnt_q == 4'd0) begin
`ifdef READBACK_CHECK_EN
                        if (we_q) begin
                            if (mem_datr != mem_datw) begin
                                chk_err <= 1'b1;
                            end
                        end else begin
                            rsp_dat   <= mem_datr;
                            rsp_valid <= 1'b1;
                        end
`else
                        rsp_dat   <= mem_datr;
                        rsp_valid <= 1'b1;
`endif
                        if (GAP == 0) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            cnt_q   <= GapLoad;
                            state_q <= StGap;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef READBACK_CHECK_EN
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master: instance a (RD_LAT=1, GAP=2), instance b (RD_LAT=3, GAP=0).
module tb_mem_access_master;

    localparam int unsigned RdLatA = 1;
    localparam int unsigned GapA   = 2;
`ifdef READBACK_CHECK_EN
    localparam int unsigned WrSp = 3 + RdLatA + GapA;
`else
    localparam int unsigned WrSp = 2 + GapA;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       cmd_valid_a, cmd_ready_a, cmd_we_a;
    logic [7:0] cmd_add_a, cmd_dat_a, mem_add_a, mem_datw_a, mem_datr_a, rsp_dat_a;
    logic       mem_en_a, mem_we_a, rsp_valid_a, busy_a, chk_err_a;

    logic       cmd_valid_b, cmd_ready_b, cmd_we_b;
    logic [7:0] cmd_add_b, cmd_dat_b, mem_add_b, mem_datw_b, mem_datr_b, rsp_dat_b;
    logic       mem_en_b, mem_we_b, rsp_valid_b, busy_b, chk_err_b;

    mem_access_master #(.AW(8), .DW(8), .RD_LAT(RdLatA), .GAP(GapA)) u_a (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_we(cmd_we_a),
        .cmd_add(cmd_add_a), .cmd_dat(cmd_dat_a),
        .mem_add(mem_add_a), .mem_datw(mem_datw_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
        .mem_datr(mem_datr_a),
        .rsp_valid(rsp_valid_a), .rsp_dat(rsp_dat_a), .busy(busy_a), .chk_err(chk_err_a)
    );

    mem_access_master #(.AW(8), .DW(8), .RD_LAT(3), .GAP(0)) u_b (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_we(cmd_we_b),
        .cmd_add(cmd_add_b), .cmd_dat(cmd_dat_b),
        .mem_add(mem_add_b), .mem_datw(mem_datw_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
        .mem_datr(mem_datr_b),
        .rsp_valid(rsp_valid_b), .rsp_dat(rsp_dat_b), .busy(busy_b), .chk_err(chk_err_b)
    );

    // Memory models: a is a RAM (optionally corrupting bit 0 on write), b is a ROM of add*3+1.
    logic [7:0] mem_a [256];
    logic       corrupt_a;
    always @(posedge clk) begin
        if (mem_en_a && mem_we_a) begin
            mem_a[mem_add_a] <= corrupt_a ? (mem_datw_a ^ 8'h01) : mem_datw_a;
        end
        mem_datr_a <= mem_a[mem_add_a];
        mem_datr_b <= 8'(mem_add_b * 8'd3 + 8'd1);
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command on a, returns in the ACCESS cycle after checking the strobes.
    task automatic issue_a(input logic we, input logic [7:0] add, input logic [7:0] dat);
        int k;
        k = 0;
        while (!cmd_ready_a && k < 40) begin
            step();
            k++;
        end
        cmd_valid_a = 1'b1;
        cmd_we_a    = we;
        cmd_add_a   = add;
        cmd_dat_a   = dat;
        step();
        cmd_valid_a = 1'b0;
        chk("acc_en", 32'(mem_en_a), 32'd1);
        chk("acc_we", 32'(mem_we_a), 32'(we));
        chk("acc_add", 32'(mem_add_a), 32'(add));
        if (we) chk("acc_datw", 32'(mem_datw_a), 32'(dat));
        chk("acc_busy", 32'(busy_a), 32'd1);
        chk("acc_rdy_low", 32'(cmd_ready_a), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   k;
        int   c;
        int   last;
        int   nacc;
        logic we_seen;

        rst = 1'b1;
        corrupt_a = 1'b0;
        cmd_valid_a = 1'b0; cmd_we_a = 1'b0; cmd_add_a = '0; cmd_dat_a = '0;
        cmd_valid_b = 1'b0; cmd_we_b = 1'b0; cmd_add_b = '0; cmd_dat_b = '0;
        repeat (5) step();
        rst = 1'b0;

        chk("rst_mem_en", 32'(mem_en_a), 32'd0);
        chk("rst_mem_we", 32'(mem_we_a), 32'd0);
        chk("rst_mem_add", 32'(mem_add_a), 32'd0);
        chk("rst_mem_datw", 32'(mem_datw_a), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("rst_rsp_dat", 32'(rsp_dat_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_chk_err", 32'(chk_err_a), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready_a), 32'd1);
        chk("rst_b_ready", 32'(cmd_ready_b), 32'd1);
        chk("rst_b_busy", 32'(busy_b), 32'd0);

        // Write loop: add=i, dat=i+11.
        for (int i = 0; i < 8; i++) begin
            issue_a(1'b1, 8'(i), 8'(i + 11));
            k = 1;
            while (!cmd_ready_a && k < 40) begin
                step();
                k++;
            end
            chk("wr_spacing", 32'(k), 32'(WrSp));
        end
        chk("mem_a_0", 32'(mem_a[0]), 32'd11);
        chk("mem_a_7", 32'(mem_a[7]), 32'd18);
        chk("chk_err_clean", 32'(chk_err_a), 32'd0);

        // Read loop: expect 11..18, 3 cycles after each accept.
        we_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue_a(1'b0, 8'(i), 8'h00);
            k = 1;
            while (!rsp_valid_a && k < 40) begin
                we_seen |= mem_we_a;
                step();
                k++;
            end
            chk("rd_latency", 32'(k), 32'd3);
            chk("rd_dat", 32'(rsp_dat_a), 32'(i + 11));
            step();
            we_seen |= mem_we_a;
            chk("rd_pulse_end", 32'(rsp_valid_a), 32'd0);
        end
        chk("rd_no_we", 32'(we_seen), 32'd0);

        // Instance b: back-to-back reads with cmd_valid held, add 0..3.
        cmd_valid_b = 1'b1;
        cmd_we_b = 1'b0;
        cmd_add_b = 8'd0;
        nacc = 0;
        last = 0;
        c = 0;
        while (nacc < 4 && c < 60) begin
            if (cmd_ready_b) begin
                if (nacc > 0) begin
                    chk("b_spacing", 32'(c - last), 32'd5);
                    chk("b_coincide", 32'(rsp_valid_b), 32'd1);
                    chk("b_rsp_dat", 32'(rsp_dat_b), 32'((nacc - 1) * 3 + 1));
                end
                last = c;
                nacc++;
                step();
                c++;
                cmd_add_b = 8'(nacc);
            end else begin
                step();
                c++;
            end
        end
        chk("b_accepts", 32'(nacc), 32'd4);
        cmd_valid_b = 1'b0;
        repeat (6) step();

        // Reset during RDWAIT aborts the read.
        issue_a(1'b0, 8'd5, 8'h00);
        step();
        chk("abort_busy_pre", 32'(busy_a), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_ready", 32'(cmd_ready_a), 32'd1);
        chk("abort_mem_en", 32'(mem_en_a), 32'd0);
        step();
        chk("abort_no_late_rsp", 32'(rsp_valid_a), 32'd0);
        issue_a(1'b0, 8'd6, 8'h00);
        k = 1;
        while (!rsp_valid_a && k < 40) begin
            step();
            k++;
        end
        chk("post_abort_latency", 32'(k), 32'd3);
        chk("post_abort_dat", 32'(rsp_dat_a), 32'd17);

`ifdef READBACK_CHECK_EN
        // Corrupting write: verify read must flag chk_err and keep it until reset.
        repeat (4) step();
        corrupt_a = 1'b1;
        issue_a(1'b1, 8'd3, 8'h5A);
        step();
        corrupt_a = 1'b0;
        k = 2;
        while (!chk_err_a && k < 40) begin
            step();
            k++;
        end
        chk("chk_err_latency", 32'(k), 32'(3 + RdLatA));
        repeat (10) step();
        chk("chk_err_sticky", 32'(chk_err_a), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("chk_err_rst", 32'(chk_err_a), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
